// File: rtl/pipelined_ripple_adder_if.sv
// Operand/result bundle for pipelined_ripple_adder.
//   master (producer/consumer side): drives en, in_valid, sub, a, b, c_in;
//                                    observes out_valid, sum, c_out, ovf.
//   slave  (adder side):             the mirror image.
interface pipelined_ripple_adder_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic             in_valid;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output en, in_valid, sub, a, b, c_in,
        input  out_valid, sum, c_out, ovf
    );

    modport slave (
        input  en, in_valid, sub, a, b, c_in,
        output out_valid, sum, c_out, ovf
    );
endinterface

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor built from one-bit full-adder cells.
// The WIDTH-bit operation is cut into N = WIDTH/SEG segments; stage k ripples
// segment k and registers its carry into stage k+1 one enabled cycle later.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of pipelined_ripple_adder_if
//              en (advance/stall), in_valid, sub, a, b, c_in  -> in
//              out_valid, sum, c_out, ovf                      -> out
// Result = a + b + c_in (sub=0) or a + ~b + 1 (sub=1), modulo 2^WIDTH.
// Latency N enabled edges, one operation per enabled cycle.

// One-bit full-adder cell.
module pra_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module pipelined_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    pipelined_ripple_adder_if.slave bus
);
    localparam int N = WIDTH / SEG;

    // Per-stage view of one operation. Each stage register holds the whole
    // operand/result word: operand bits above the stage act as the skew line,
    // result bits at and below it act as the deskew line. Bits a stage never
    // reads are constant-propagated away by synthesis.
    logic [WIDTH-1:0] w_ain  [N];
    logic [WIDTH-1:0] w_bin  [N];
    logic [WIDTH-1:0] w_rin  [N];
    logic             w_cin  [N];
    logic             w_vin  [N];
    logic [WIDTH-1:0] w_rout [N];

    logic [WIDTH-1:0] r_a [N];
    logic [WIDTH-1:0] r_b [N];
    logic [WIDTH-1:0] r_r [N];
    logic             r_c [N];
    logic             r_v [N];
    logic             r_ovf;

    logic [WIDTH-1:0] w_fs;
    logic [WIDTH-1:0] w_fci;
    logic [WIDTH-1:0] w_fco;
    logic             w_ovf;

    // Stage inputs: stage 0 sees the ports (b inverted and forced carry for
    // subtract), later stages see the previous stage's registers.
    always_comb begin
        w_ain[0] = bus.a;
        w_bin[0] = bus.sub ? ~bus.b : bus.b;
        w_rin[0] = '0;
        w_cin[0] = bus.sub | bus.c_in;
        w_vin[0] = bus.in_valid;
        for (int s = 1; s < N; s++) begin
            w_ain[s] = r_a[s-1];
            w_bin[s] = r_b[s-1];
            w_rin[s] = r_r[s-1];
            w_cin[s] = r_c[s-1];
            w_vin[s] = r_v[s-1];
        end
    end

    // Ripple chain: the LSB cell of each segment takes that stage's
    // registered carry instead of the neighbouring cell's carry-out.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam int S = i / SEG;
        if (i % SEG == 0) begin : g_lsb
            assign w_fci[i] = w_cin[S];
        end else begin : g_mid
            assign w_fci[i] = w_fco[i-1];
        end
        pra_fa u_fa (
            .i_a  (w_ain[S][i]),
            .i_b  (w_bin[S][i]),
            .i_ci (w_fci[i]),
            .o_s  (w_fs[i]),
            .o_co (w_fco[i])
        );
    end

    // Each stage overlays its freshly computed segment onto the partial result.
    always_comb begin
        for (int s = 0; s < N; s++) begin
            w_rout[s] = w_rin[s];
            w_rout[s][s*SEG +: SEG] = w_fs[s*SEG +: SEG];
        end
    end

    // Signed overflow from the MSB cell, which always belongs to the last stage.
    assign w_ovf = w_fci[WIDTH-1] ^ w_fco[WIDTH-1];

    // Data registers load only behind a valid operation so bubbles leave the
    // previous result visible on the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < N; s++) begin
                r_v[s] <= 1'b0;
                r_a[s] <= '0;
                r_b[s] <= '0;
                r_r[s] <= '0;
                r_c[s] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (bus.en) begin
            for (int s = 0; s < N; s++) begin
                r_v[s] <= w_vin[s];
                if (w_vin[s]) begin
                    r_a[s] <= w_ain[s];
                    r_b[s] <= w_bin[s];
                    r_r[s] <= w_rout[s];
                    r_c[s] <= w_fco[(s+1)*SEG-1];
                end
            end
            if (w_vin[N-1]) r_ovf <= w_ovf;
        end
    end

    assign bus.out_valid = r_v[N-1];
    assign bus.sum       = r_r[N-1];
    assign bus.c_out     = r_c[N-1];
    assign bus.ovf       = r_ovf;
endmodule

// File: doc/pipelined_ripple_adder.md
# pipelined_ripple_adder

Parametrised, pipelined ripple-carry adder/subtractor built from one-bit full-adder cells. The WIDTH-bit operation is split into SEG-bit segments, with one segment per pipeline stage. Each stage's carry-out is registered into the next stage, and operand skew/deskew registers keep each result word aligned. The block sits in the FIR datapath wherever a wide accumulation or tap sum must close timing at full clock rate. It accepts one operation per enabled cycle and supports stall.

## Interface
- WIDTH, 16, operand/result width in bits; must be a positive multiple of SEG.
- SEG, 4, bits per pipeline stage; number of stages N = WIDTH/SEG (N=1 is legal: single registered stage).
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  pipeline advance; when 0 every register (data and valid) holds.
- in_valid  input  1  operands on a/b/c_in/sub are a new operation (sampled only when en=1).
- sub  input  1  0: a+b+c_in; 1: a−b, computed as a+~b+1 (c_in ignored).
- a  input  WIDTH  operand A (two's complement or unsigned; the adder is sign-agnostic).
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in for add mode.
- out_valid  output  1  sum/c_out/ovf carry a completed operation this cycle.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- c_out  output  1  carry out of MSB; in sub mode 1 = no borrow (a ≥ b unsigned).
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- Stage 0 computes segment 0 (bits SEG−1:0) on the input operands with carry-in = sub ? 1 : c_in, using ~b when sub=1.
- Stage k (1..N−1) adds segment k of the skewed operands plus the registered carry from stage k−1.
- Operand segment k is delayed k cycles (skew). Result segment k is delayed N−1−k cycles (deskew), so all bits of one operation leave together.
- A valid bit travels with each operation through an N-deep valid shift chain. out_valid is its last element.
- Data registers of a stage load only when that stage's valid bit is being loaded as 1. Bubbles (in_valid=0) therefore never disturb data.
- Consequence: sum/c_out/ovf hold the most recent completed result while out_valid=0.
- ovf is formed in the last stage from the MSB cell's carry-in and carry-out, and registered with sum.
- No internal saturation; wrap-around is modulo 2^WIDTH.
- Operations complete strictly in issue order; there is no reordering, drop, or duplication.

## Timing
- Reset (asynchronous, immediate on rst rising): out_valid=0, sum=0, c_out=0, ovf=0; all internal valid bits, carry, skew and deskew registers cleared.
- Reset mid-operation: all in-flight operations are discarded. The first operation accepted after rst deasserts is the first to emerge.
- Latency: an operation sampled at edge E (en=1, in_valid=1) appears with out_valid=1 after edge E+N−1 of enabled edges, i.e. N enabled edges including E. Each cycle with en=0 adds exactly one cycle.
- Throughput: one operation per enabled cycle; back-to-back in_valid is legal with no bubble.
- en=0: outputs and all state frozen. If out_valid=1, it stays 1 and shows the same result, so downstream must qualify with en when counting results.
- en and in_valid are sampled together; in_valid with en=0 is ignored (not queued).
- Carry boundary: a carry generated in stage k reaches stage k+1 exactly one enabled cycle later, together with that operation's next operand segment.

## Test plan
(All scenarios use WIDTH=16, SEG=4, so N=4.)
- Reset: assert rst asynchronously mid-cycle with traffic in flight -> out_valid, sum, c_out, ovf all 0 immediately. After release, no stale result emerges.
- Basic add: a=0x1234, b=0x4321, c_in=0, sub=0 at edge E -> after edge E+3 out_valid=1, sum=0x5555, c_out=0, ovf=0.
- Full ripple across stages: a=0xFFFF, b=0x0000, c_in=1 -> sum=0x0000, c_out=1, ovf=0. Then a=0x7FFF, b=0x0001, c_in=0 -> sum=0x8000, c_out=0, ovf=1.
- Subtract: sub=1, a=0x0003, b=0x0005, c_in=1 (ignored) -> sum=0xFFFE, c_out=0, ovf=0. Then sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, c_out=1, ovf=1.
- Stream with stall: issue 0x0001+0x0001, 0x00FF+0x0001, 0x0FFF+0x0001 on consecutive cycles, then drop en for 2 cycles after the second issue -> results 0x0002, 0x0100, 0x1000 appear in order. Each appears once per enabled cycle, and latency is extended by exactly 2 cycles.
- Bubbles: alternate in_valid 1/0 with random operands (golden model a±b) for 1000 ops. Check that out_valid reproduces the input pattern delayed by 4, and that sum holds its value across bubble cycles.
